// File: rtl/traffic_controller_if.sv
// Bundle between the VGA timing / player stages and the traffic controller.
// The slave side is the controller: it consumes counters and player state
// and publishes car positions, the speed level and the event pulses.
interface traffic_controller_if;
  logic [9:0] h_count;
  logic [9:0] v_count;
  logic [9:0] player_x;
  logic [9:0] player_y;
  logic       level_up;
  logic       pause;
  logic [9:0] car_x;
  logic [9:0] car2_x;
  logic [9:0] car3_x;
  logic [9:0] car4_x;
  logic [9:0] car_y;
  logic [9:0] car2_y;
  logic [9:0] car3_y;
  logic [9:0] car4_y;
  logic [2:0] level;
  logic       frame_tick;
  logic       hit;

  modport master (
    output h_count, v_count, player_x, player_y, level_up, pause,
    input  car_x, car2_x, car3_x, car4_x,
    input  car_y, car2_y, car3_y, car4_y,
    input  level, frame_tick, hit
  );

  modport slave (
    input  h_count, v_count, player_x, player_y, level_up, pause,
    output car_x, car2_x, car3_x, car4_x,
    output car_y, car2_y, car3_y, car4_y,
    output level, frame_tick, hit
  );
endinterface

// File: rtl/traffic_controller.sv
// Per-frame game-state update: moves four lane cars during vertical
// blanking, wraps them at the screen edges and detects player collisions
// with a frame-counted cooldown between hits.
module traffic_controller #(
  parameter int H_DISPLAY     = 640,
  parameter int V_DISPLAY     = 480,
  parameter int CAR_WIDTH     = 32,
  parameter int CAR_HEIGHT    = 32,
  parameter int PLAYER_WIDTH  = 32,
  parameter int PLAYER_HEIGHT = 32,
  parameter int LANE_Y0       = 96,
  parameter int LANE_Y1       = 192,
  parameter int LANE_Y2       = 288,
  parameter int LANE_Y3       = 384,
  parameter int HIT_COOLDOWN  = 60
) (
  input  logic                  CLK,
  input  logic                  RST,
  traffic_controller_if.slave   bus
);

  localparam int CD_RAW = $clog2(HIT_COOLDOWN + 1);
  localparam int CD_W   = (CD_RAW < 6) ? 6 : CD_RAW;

  localparam logic [10:0] H_DISP11 = 11'(H_DISPLAY);
  localparam logic [10:0] CAR_W11  = 11'(CAR_WIDTH);
  localparam logic [10:0] CAR_H11  = 11'(CAR_HEIGHT);
  localparam logic [10:0] PLR_W11  = 11'(PLAYER_WIDTH);
  localparam logic [10:0] PLR_H11  = 11'(PLAYER_HEIGHT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MOVE  = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [2:0]        level_reg;
  logic              frame_tick_reg, frame_tick_next;
  logic              hit_reg, hit_next;
  logic [CD_W-1:0]   cooldown_reg, cooldown_next;
  logic [9:0]        pos_reg  [4];
  logic [9:0]        pos_next [4];
  logic [9:0]        pos_init [4];
  logic [9:0]        lane_y   [4];
  logic [3:0]        overlap;

  logic              frame_match;
  logic              any_overlap;
  logic [10:0]       px11;
  logic [10:0]       py11;

  assign frame_match = (bus.h_count == 10'd0) && (bus.v_count == 10'(V_DISPLAY));
  assign px11        = {1'b0, bus.player_x};
  assign py11        = {1'b0, bus.player_y};
  assign any_overlap = |overlap;

  // Per-lane motion, wrap and overlap. Even lanes travel right, odd lanes
  // travel left; lane k runs k px/frame faster than lane 0. Cars start
  // spread evenly across the screen width.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [9:0] LY = (gi == 0) ? 10'(LANE_Y0) :
                                  (gi == 1) ? 10'(LANE_Y1) :
                                  (gi == 2) ? 10'(LANE_Y2) : 10'(LANE_Y3);

      logic [3:0]  speed;
      logic [9:0]  speed10;
      logic [10:0] sum11;
      logic [10:0] cx11;
      logic [10:0] cy11;

      assign speed   = {1'b0, level_reg} + 4'(gi + 1);
      assign speed10 = {6'b0, speed};
      assign sum11   = {1'b0, pos_reg[gi]} + {7'b0, speed};
      assign cx11    = {1'b0, pos_reg[gi]};
      assign cy11    = {1'b0, LY};

      assign lane_y[gi]   = LY;
      assign pos_init[gi] = 10'(gi * (H_DISPLAY / 4));

      if (gi % 2 == 0) begin : g_right
        assign pos_next[gi] = (sum11 >= H_DISP11) ? 10'(sum11 - H_DISP11)
                                                  : 10'(sum11);
      end else begin : g_left
        assign pos_next[gi] = (pos_reg[gi] < speed10)
                            ? 10'(cx11 + H_DISP11 - {7'b0, speed})
                            : (pos_reg[gi] - speed10);
      end

      // Strict inequalities: rectangles that only touch do not collide.
      assign overlap[gi] = (px11 < cx11 + CAR_W11) && (cx11 < px11 + PLR_W11) &&
                           (py11 < cy11 + CAR_H11) && (cy11 < py11 + PLR_H11);
    end
  endgenerate

  // Next-state, event pulses and cooldown bookkeeping.
  always_comb begin
    state_next      = state_reg;
    frame_tick_next = 1'b0;
    hit_next        = 1'b0;
    cooldown_next   = cooldown_reg;
    case (state_reg)
      IDLE: begin
        if (frame_match) begin
          state_next      = MOVE;
          frame_tick_next = 1'b1;
        end
      end
      MOVE: begin
        state_next = CHECK;
        // Cooldown counts frames, so it keeps running while paused.
        if (cooldown_reg != '0) begin
          cooldown_next = cooldown_reg - 1'b1;
        end
      end
      CHECK: begin
        state_next = IDLE;
        if (any_overlap && (cooldown_reg == '0)) begin
          hit_next      = 1'b1;
          cooldown_next = CD_W'(HIT_COOLDOWN);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM, pulse and cooldown registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg      <= IDLE;
      frame_tick_reg <= 1'b0;
      hit_reg        <= 1'b0;
      cooldown_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      frame_tick_reg <= frame_tick_next;
      hit_reg        <= hit_next;
      cooldown_reg   <= cooldown_next;
    end
  end

  // Speed level: accepted at any time, saturates at the top level.
  always_ff @(posedge CLK) begin
    if (RST) begin
      level_reg <= 3'd0;
    end else if (bus.level_up && (level_reg != 3'd7)) begin
      level_reg <= level_reg + 3'd1;
    end
  end

  // Car positions commit once per frame at the end of MOVE unless paused.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < 4; i++) begin
      if (RST) begin
        pos_reg[i] <= pos_init[i];
      end else if ((state_reg == MOVE) && !bus.pause) begin
        pos_reg[i] <= pos_next[i];
      end
    end
  end

  assign bus.car_x      = pos_reg[0];
  assign bus.car2_x     = pos_reg[1];
  assign bus.car3_x     = pos_reg[2];
  assign bus.car4_x     = pos_reg[3];
  assign bus.car_y      = lane_y[0];
  assign bus.car2_y     = lane_y[1];
  assign bus.car3_y     = lane_y[2];
  assign bus.car4_y     = lane_y[3];
  assign bus.level      = level_reg;
  assign bus.frame_tick = frame_tick_reg;
  assign bus.hit        = hit_reg;

endmodule

// File: tb/tb_traffic_controller.sv
// Directed bench for traffic_controller: reset state, movement and wrap,
// level saturation, pause, collision/cooldown and reset during an update.
module tb_traffic_controller;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  traffic_controller_if bus();

  traffic_controller dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int   checks   = 0;
  int   failures = 0;
  logic ft_hist  [4];
  logic hit_hist [4];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s got=%0d", tag, got);
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic pulse_level_up();
    bus.level_up = 1'b1;
    @(posedge CLK);
    #1;
    bus.level_up = 1'b0;
  endtask

  // One frame: present the match for one edge (E), then record
  // frame_tick/hit after edges E..E+3, then one idle cycle.
  task automatic do_frame();
    bus.h_count = 10'd0;
    bus.v_count = 10'd480;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK);
      #1;
      if (i == 0) begin
        bus.h_count = 10'd1;
        bus.v_count = 10'd0;
      end
      ft_hist[i]  = bus.frame_tick;
      hit_hist[i] = bus.hit;
    end
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [3:0] hit_pattern();
    return {hit_hist[0], hit_hist[1], hit_hist[2], hit_hist[3]};
  endfunction

  function automatic logic [3:0] ft_pattern();
    return {ft_hist[0], ft_hist[1], ft_hist[2], ft_hist[3]};
  endfunction

  initial begin
    bus.h_count  = 10'd1;
    bus.v_count  = 10'd0;
    bus.player_x = 10'd600;
    bus.player_y = 10'd0;
    bus.level_up = 1'b0;
    bus.pause    = 1'b0;

    // Reset state
    do_reset();
    check_val("rst_car_x",  bus.car_x,  0);
    check_val("rst_car2_x", bus.car2_x, 160);
    check_val("rst_car3_x", bus.car3_x, 320);
    check_val("rst_car4_x", bus.car4_x, 480);
    check_val("rst_car_y",  bus.car_y,  96);
    check_val("rst_car2_y", bus.car2_y, 192);
    check_val("rst_car3_y", bus.car3_y, 288);
    check_val("rst_car4_y", bus.car4_y, 384);
    check_val("rst_level",  bus.level,  0);
    check_val("rst_tick",   bus.frame_tick, 0);
    check_val("rst_hit",    bus.hit,    0);

    // First frame at level 0: speeds 1,2,3,4
    do_frame();
    check_val("f1_tick_pattern", ft_pattern(), 4'b1000);
    check_val("f1_car_x",  bus.car_x,  1);
    check_val("f1_car2_x", bus.car2_x, 158);
    check_val("f1_car3_x", bus.car3_x, 323);
    check_val("f1_car4_x", bus.car4_x, 476);
    check_val("f1_no_hit", hit_pattern(), 4'b0000);

    // Right-edge wrap of lane 0: 638 frames -> 638, 639 -> 639, 640 -> 0
    for (int f = 2; f <= 638; f++) do_frame();
    check_val("wrap_car_x_638", bus.car_x, 638);
    do_frame();
    check_val("wrap_car_x_639", bus.car_x, 639);
    do_frame();
    check_val("wrap_car_x_0",   bus.car_x, 0);
    // After 640 frames every lane has completed whole laps
    check_val("wrap_car2_x_lap", bus.car2_x, 160);
    check_val("wrap_car3_x_lap", bus.car3_x, 320);
    check_val("wrap_car4_x_lap", bus.car4_x, 480);

    // Left-edge wrap of lane 1 at level 1 (speed 3): 160-3*53=1, then 638
    do_reset();
    pulse_level_up();
    check_val("l1_level", bus.level, 1);
    for (int f = 1; f <= 53; f++) do_frame();
    check_val("lwrap_car2_x_1",   bus.car2_x, 1);
    do_frame();
    check_val("lwrap_car2_x_638", bus.car2_x, 638);
    check_val("lwrap_car_x_108",  bus.car_x,  108);

    // Level saturation: 9 pulses stop at 7; speeds become 8,9,10,11
    do_reset();
    for (int p = 0; p < 9; p++) pulse_level_up();
    check_val("sat_level", bus.level, 7);
    do_frame();
    check_val("sat_car_x",  bus.car_x,  8);
    check_val("sat_car2_x", bus.car2_x, 151);
    check_val("sat_car3_x", bus.car3_x, 330);
    check_val("sat_car4_x", bus.car4_x, 469);

    // Reset on the same edge as level_up wins
    RST = 1'b1;
    bus.level_up = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    bus.level_up = 1'b0;
    check_val("rst_vs_lvlup_level", bus.level, 0);
    check_val("rst_vs_lvlup_car_x", bus.car_x, 0);

    // Pause: three frames without motion, ticks continue, level_up accepted
    bus.pause = 1'b1;
    for (int f = 0; f < 3; f++) begin
      do_frame();
      check_val($sformatf("pause_tick_%0d", f), ft_pattern(), 4'b1000);
      check_val($sformatf("pause_car_x_%0d", f), bus.car_x, 0);
      check_val($sformatf("pause_car4_x_%0d", f), bus.car4_x, 480);
      if (f == 1) pulse_level_up();
    end
    check_val("pause_level", bus.level, 1);
    bus.pause = 1'b0;
    do_frame();
    check_val("unpause_car_x",  bus.car_x,  2);
    check_val("unpause_car2_x", bus.car2_x, 157);
    check_val("unpause_car3_x", bus.car3_x, 324);
    check_val("unpause_car4_x", bus.car4_x, 475);

    // Touching rectangles do not collide
    do_reset();
    bus.pause    = 1'b1;
    bus.player_x = 10'd32;
    bus.player_y = 10'd96;
    do_frame();
    check_val("touch_right_no_hit", hit_pattern(), 4'b0000);
    bus.player_x = 10'd0;
    bus.player_y = 10'd64;
    do_frame();
    check_val("touch_above_no_hit", hit_pattern(), 4'b0000);

    // Collision and cooldown (paused, so the lane-0 car stays at x=0)
    bus.player_x = 10'd0;
    bus.player_y = 10'd96;
    do_frame();
    check_val("hit_first_pattern", hit_pattern(), 4'b0010);
    for (int f = 2; f <= 60; f++) begin
      do_frame();
      check_val($sformatf("cd_no_hit_f%0d", f), hit_pattern(), 4'b0000);
    end
    do_frame();
    check_val("cd_hit_f61", hit_pattern(), 4'b0010);

    // Reset asserted during CHECK drops the update and the hit
    do_reset();
    bus.pause    = 1'b0;
    bus.player_x = 10'd1;
    bus.player_y = 10'd96;
    bus.h_count  = 10'd0;
    bus.v_count  = 10'd480;
    @(posedge CLK);
    #1;
    bus.h_count = 10'd1;
    bus.v_count = 10'd0;
    check_val("midrst_tick", bus.frame_tick, 1);
    @(posedge CLK);
    #1;
    check_val("midrst_moved_car_x", bus.car_x, 1);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check_val("midrst_hit",    bus.hit,    0);
    check_val("midrst_car_x",  bus.car_x,  0);
    check_val("midrst_car2_x", bus.car2_x, 160);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    check_val("midrst_hit_after", bus.hit, 0);
    do_frame();
    check_val("midrst_next_car_x", bus.car_x, 1);
    check_val("midrst_next_car4_x", bus.car4_x, 476);
    check_val("midrst_next_hit", hit_pattern(), 4'b0010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
